// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner, debouncer and encoder.
//
// Ports:
//   clk       in   system clock (1 kHz), rising edge
//   rst_n     in   asynchronous active-low reset
//   row[3:0]  in   keypad rows, active-low, asynchronous to clk
//   col[3:0]  out  column drive, active-low one-hot (registered)
//   key[3:0]  out  key code for exactly one cycle per accepted press, 4'hF idle
//   key_held  out  high while the accepted key stays down (incl. release debounce)
//
// Parameters:
//   SETTLE    cycles each column is driven before rows are sampled (>= 3)
//   DEBOUNCE  consecutive stable cycles required for press and for release
module keypad_scan #(
  parameter int unsigned SETTLE   = 3,
  parameter int unsigned DEBOUNCE = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_held
);

  typedef enum logic [2:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_EMIT,
    S_HOLD,
    S_RELEASE
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] DEB_LAST    = 8'(DEBOUNCE - 1);

  state_e     state_q, state_d;
  logic [3:0] row_m_q, row_s_q;
  logic [1:0] cidx_q, cidx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] rpat_q, rpat_d;
  logic [3:0] col_q, col_d;
  logic [3:0] key_q, key_d;
  logic       held_q, held_d;

  logic [3:0] row_low;
  logic       single_low;
  logic [1:0] ridx;
  logic [3:0] code;

  // Exactly one low row: inverted pattern is non-zero and a power of two.
  assign row_low    = ~row_s_q;
  assign single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);

  always_comb begin
    ridx = 2'd0;
    case (rpat_q)
      4'b1110: ridx = 2'd0;
      4'b1101: ridx = 2'd1;
      4'b1011: ridx = 2'd2;
      4'b0111: ridx = 2'd3;
      default: ridx = 2'd0;
    endcase
  end

  // '#' (r3c2) maps to 4'hF so it is debounced and held but emits nothing.
  always_comb begin
    code = 4'hF;
    case ({ridx, cidx_q})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      4'd15: code = 4'hD;
      default: code = 4'hF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    cnt_d   = cnt_q + 8'd1;
    rpat_d  = rpat_q;
    key_d   = 4'hF;
    case (state_q)
      S_SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (single_low) begin
            rpat_d  = row_s_q;
            state_d = S_DEBOUNCE;
          end else begin
            cidx_d = cidx_q + 2'd1;
          end
        end
      end
      S_DEBOUNCE: begin
        if (row_s_q != rpat_q) begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_EMIT;
          cnt_d   = '0;
          key_d   = code;   // registered, so key is valid during EMIT
        end
      end
      S_EMIT: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
      S_HOLD: begin
        if (row_s_q == 4'hF) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (row_s_q != 4'hF) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = S_SCAN;
          cidx_d  = 2'd0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_SCAN;
        cidx_d  = 2'd0;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == S_HOLD) || (state_d == S_RELEASE);
    col_d  = ~(4'b0001 << cidx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SCAN;
      row_m_q <= '1;
      row_s_q <= '1;
      cidx_q  <= '0;
      cnt_q   <= '0;
      rpat_q  <= '1;
      col_q   <= 4'b1110;
      key_q   <= 4'hF;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_m_q <= row;
      row_s_q <= row_m_q;
      cidx_q  <= cidx_d;
      cnt_q   <= cnt_d;
      rpat_q  <= rpat_d;
      col_q   <= col_d;
      key_q   <= key_d;
      held_q  <= held_d;
    end
  end

  assign col      = col_q;
  assign key      = key_q;
  assign key_held = held_q;

endmodule
